// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_streamer
//  Description : Frame buffer that the host fills while the block is idle and
//                that is streamed out in row-major order on request. Each
//                streamed pixel is added to a running 16-bit checksum.
//                Downstream can stall the stream with hold.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1   rising-edge clock
//    reset     in   1   asynchronous, active-low reset
//    wr_en     in   1   host buffer write strobe (honoured only while idle)
//    wr_addr   in   AW  host write address, row*COLS+col
//    wr_data   in   8   host write pixel
//    start     in   1   request to stream the buffered frame
//    hold      in   1   downstream stall request
//    data      out  8   streamed pixel
//    data_en   out  1   data carries a valid pixel this cycle
//    busy      out  1   high while streaming
//    done      out  1   one-cycle end-of-frame pulse
//    checksum  out  16  modulo-2^16 sum of the pixels streamed so far
// ============================================================================
module frame_streamer #(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic          hold,
  output logic [7:0]    data,
  output logic          data_en,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum
);

  localparam int            DEPTH    = ROWS * COLS;
  localparam int            LAST     = DEPTH - 1;
  localparam logic [AW-1:0] LAST_IDX = LAST[AW-1:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] index_q;
  logic [7:0]    data_q;
  logic          data_en_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   checksum_q;

  // Frame buffer. Deliberately not reset: contents survive a reset so an
  // aborted frame can be replayed from the retained image.
  logic [7:0]    mem_q [DEPTH];

  logic          addr_ok;
  logic          wr_fire;
  logic [7:0]    pixel;

  // When the buffer fills the whole address space every address is legal and
  // the range compare would be constant, so it is only built when needed.
  generate
    if (DEPTH >= (1 << AW)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_partial_range
      localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
      assign addr_ok = ({1'b0, wr_addr} < DEPTH_W);
    end
  endgenerate

  // Host writes land only while idle. A write that coincides with start is
  // still committed, since the state is IDLE on that edge.
  assign wr_fire = wr_en && addr_ok && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Row-major order means the pixel index is the buffer address itself.
  assign pixel = mem_q[index_q];

  // Control FSM with registered outputs.
  // Timeline at the end of a frame:
  //   edge E   : last pixel registered, state -> DONE, busy drops
  //   edge E+1 : (in DONE) data_en cleared, done raised, state -> IDLE
  //   edge E+2 : (in IDLE) done cleared; start may already be taken here
  // done is raised on the edge leaving DONE so it never overlaps data_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      data_q     <= '0;
      data_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_en_q <= 1'b0;
          done_q    <= 1'b0;
          if (start) begin
            state_q    <= ST_STREAM;
            index_q    <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b1;
          end
        end

        ST_STREAM: begin
          if (hold) begin
            // Stall: no pixel, index and checksum frozen, data keeps last value.
            data_en_q <= 1'b0;
          end else begin
            data_q     <= pixel;
            data_en_q  <= 1'b1;
            checksum_q <= checksum_q + {8'h00, pixel};
            if (index_q == LAST_IDX) begin
              state_q <= ST_DONE;
              index_q <= '0;
              busy_q  <= 1'b0;
            end else begin
              index_q <= index_q + AW'(1);
            end
          end
        end

        ST_DONE: begin
          data_en_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q   <= ST_IDLE;
          data_en_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data     = data_q;
  assign data_en  = data_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_streamer
//  Description : Directed plus randomized bench for frame_streamer. A
//                behavioural frame model (array indexed by row/col) supplies
//                expected pixels, running sums and frame checksums.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_streamer;

  localparam int ROWS   = 16;
  localparam int COLS   = 8;
  localparam int AW     = 7;
  localparam int DEPTH  = ROWS * COLS;
  localparam int BUDGET = 4 * DEPTH + 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          hold;
  logic [7:0]    data;
  logic          data_en;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_buf [DEPTH];

  frame_streamer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .hold     (hold),
    .data     (data),
    .data_en  (data_en),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k-th pixel of a frame: row-major walk over the image.
  function automatic logic [7:0] exp_pixel(input int k);
    int r;
    int c;
    r = k / COLS;
    c = k % COLS;
    return ref_buf[r * COLS + c];
  endfunction

  function automatic logic [15:0] frame_sum();
    int s;
    s = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        s += ref_buf[r * COLS + c];
    return 16'(s % 65536);
  endfunction

  task automatic write_px(input int addr, input logic [7:0] val);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = val;
    ref_buf[addr] = val;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Streams one frame and checks it against the model.
  //   rnd_hold   : random stalls on every cycle
  //   hold_after : after pixel hold_after, hold for hold_len cycles
  //   poke_kind  : 1 = pulse start, 2 = write 0xFF to addr 3, after pixel poke_after
  //   sw_*       : host write issued together with the start pulse
  task automatic run_frame(input string tag, input bit rnd_hold,
                           input int hold_after, input int hold_len,
                           input int poke_after, input int poke_kind,
                           input bit sw_en, input int sw_addr, input logic [7:0] sw_data);
    int cyc, pulses, dones, first_cyc, last_cyc, done_cyc;
    int holds, holds_pre, hold_left;
    int px_err, sum_err, busy_err, hold_err, dd_err;
    bit hold_trig, poked;
    logic [15:0] run_sum, exp_sum;
    logic [7:0]  last_px;

    start   = 1'b1;
    wr_en   = sw_en;
    wr_addr = sw_addr[AW-1:0];
    wr_data = sw_data;
    if (sw_en) ref_buf[sw_addr] = sw_data;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, ":busy_at_start"}, busy, 1);
    check({tag, ":sum_cleared"}, checksum, 0);

    exp_sum = frame_sum();
    cyc = 0; pulses = 0; dones = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    holds = 0; holds_pre = 0; hold_left = 0;
    px_err = 0; sum_err = 0; busy_err = 0; hold_err = 0; dd_err = 0;
    hold_trig = 1'b0; poked = 1'b0; run_sum = 16'h0; last_px = 8'h0;

    while (cyc < BUDGET && !(done_cyc >= 0 && cyc >= done_cyc + 1)) begin
      // inputs for the coming edge
      if (!hold_trig && hold_len > 0 && pulses == hold_after + 1) begin
        hold_left = hold_len;
        hold_trig = 1'b1;
      end
      if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
      else          hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      if (hold && pulses < DEPTH) begin
        holds++;
        if (pulses == 0) holds_pre++;
      end
      if (!poked && poke_kind != 0 && pulses == poke_after + 1) begin
        poked = 1'b1;
        if (poke_kind == 1) start = 1'b1;
        else begin
          wr_en = 1'b1; wr_addr = 3; wr_data = 8'hFF;
        end
      end

      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;

      if (data_en) begin
        if (pulses >= DEPTH || data !== exp_pixel(pulses)) px_err++;
        if (pulses < DEPTH) run_sum = run_sum + {8'h00, exp_pixel(pulses)};
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        last_px  = data;
        pulses++;
      end else if (pulses > 0 && pulses < DEPTH && data !== last_px) begin
        hold_err++;
      end
      if (checksum !== run_sum) sum_err++;
      if (busy !== (pulses < DEPTH)) busy_err++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        if (data_en) dd_err++;
      end
    end
    hold = 1'b0;

    check({tag, ":pulses"},        pulses, DEPTH);
    check({tag, ":pixel_errs"},    px_err, 0);
    check({tag, ":run_sum_errs"},  sum_err, 0);
    check({tag, ":busy_errs"},     busy_err, 0);
    check({tag, ":hold_data_errs"}, hold_err, 0);
    check({tag, ":done_pulses"},   dones, 1);
    check({tag, ":done_timing"},   done_cyc, last_cyc + 1);
    check({tag, ":done_with_en"},  dd_err, 0);
    check({tag, ":first_latency"}, first_cyc, 1 + holds_pre);
    check({tag, ":span"},          last_cyc, DEPTH + holds);
    check({tag, ":checksum"},      checksum, exp_sum);
  endtask

  initial begin
    int cnt;
    int cyc;

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:data",     data, 0);
    check("reset:data_en",  data_en, 0);
    check("reset:busy",     busy, 0);
    check("reset:done",     done, 0);
    check("reset:checksum", checksum, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ramp image, plain frame
    for (int i = 0; i < DEPTH; i++) write_px(i, 8'(i));
    run_frame("ramp", 1'b0, 0, 0, 0, 0, 1'b0, 0, 8'h00);
    check("ramp:checksum_const", checksum, 16'h1FC0);

    // five-cycle stall after pixel 40
    run_frame("hold40", 1'b0, 40, 5, 0, 0, 1'b0, 0, 8'h00);
    check("hold40:checksum_const", checksum, 16'h1FC0);

    // write during stream is ignored; next frame still shows 3 at index 3
    run_frame("wr_in_stream", 1'b0, 0, 0, 10, 2, 1'b0, 0, 8'h00);
    run_frame("after_wr", 1'b0, 0, 0, 0, 0, 1'b0, 0, 8'h00);
    check("after_wr:checksum_const", checksum, 16'h1FC0);

    // start re-asserted at pixel 60 is ignored
    run_frame("restart60", 1'b0, 0, 0, 59, 1, 1'b0, 0, 8'h00);

    // asynchronous reset mid-frame
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 71 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (data_en) cnt++;
    end
    check("rst_mid:reached_px70", cnt, 71);
    check("rst_mid:px70", data, exp_pixel(70));
    #2 reset = 1'b0;
    #1;
    check("rst_mid:data",     data, 0);
    check("rst_mid:data_en",  data_en, 0);
    check("rst_mid:busy",     busy, 0);
    check("rst_mid:done",     done, 0);
    check("rst_mid:checksum", checksum, 0);
    @(posedge clk); #1;
    check("rst_mid:held_busy", busy, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame("after_rst", 1'b0, 0, 0, 0, 0, 1'b0, 0, 8'h00);
    check("after_rst:checksum_const", checksum, 16'h1FC0);

    // all-0xFF image, then back-to-back frame started right after done
    for (int i = 0; i < DEPTH; i++) write_px(i, 8'hFF);
    run_frame("ones", 1'b0, 0, 0, 0, 0, 1'b0, 0, 8'h00);
    check("ones:checksum_const", checksum, 16'h7F80);
    run_frame("ones_b2b", 1'b0, 0, 0, 0, 0, 1'b0, 0, 8'h00);

    // write coinciding with start is committed
    run_frame("start_wr", 1'b0, 0, 0, 0, 0, 1'b1, 5, 8'h12);

    // random images with random stalls
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < DEPTH; i++) write_px(i, 8'($urandom_range(0, 255)));
      run_frame("random", 1'b1, 0, 0, 0, 0, 1'b0, 0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
